// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that sits directly upstream of an asynchronous
// (combinational-read) instruction ROM. The stage owns the program counter,
// drives the ROM word index from it, and captures the returned instruction
// word into the IF/ID pipeline register. It also applies the decode-stage
// stall and the execute-stage redirect, inserting a bubble where needed.
//
// Parameters
//   RESET_PC    byte address loaded into the PC on reset
//   IMEM_AW     word-address width of the instruction ROM
//   NOP_INSTR   bubble instruction placed in IF/ID when it is invalid
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   stall        in   hold PC and IF/ID (load-use hazard from decode)
//   redirect     in   branch taken / jump: load PC, squash IF/ID
//   redirect_pc  in   byte-address redirect target (bits [1:0] ignored)
//   imem_addr    out  ROM word index, combinational from pc only
//   imem_data    in   instruction word returned combinationally by the ROM
//   pc           out  current fetch PC (byte address, registered)
//   if_id_pc     out  PC of the instruction held in IF/ID
//   if_id_instr  out  instruction held in IF/ID
//   if_id_valid  out  IF/ID holds a real instruction
//   fetch_count  out  instructions accepted into IF/ID since reset
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  // What the stage does at the next rising edge, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_REDIRECT,
    ACT_STALL,
    ACT_ADVANCE
  } action_e;

  action_e     action;

  logic [31:0] pc_next;
  logic [31:0] if_id_pc_next;
  logic [31:0] if_id_instr_next;
  logic        if_id_valid_next;
  logic [31:0] fetch_count_next;

  // Word index into the ROM. Only pc[IMEM_AW+1:2] is used, so the index is
  // always in range and the address space simply aliases every 4*2^IMEM_AW
  // bytes. Driven from the registered pc only, so stall/redirect never reach
  // the ROM address combinationally.
  assign imem_addr = {{(32 - IMEM_AW){1'b0}}, pc[IMEM_AW+1:2]};

  // Priority: rst > redirect > stall > advance.
  always_comb begin
    if (rst) begin
      action = ACT_RESET;
    end else if (redirect) begin
      action = ACT_REDIRECT;
    end else if (stall) begin
      action = ACT_STALL;
    end else begin
      action = ACT_ADVANCE;
    end
  end

  // Next-state computation for the PC and the IF/ID register.
  always_comb begin
    // NOTE: every signal gets a hold default before the case so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    pc_next          = pc;
    if_id_pc_next    = if_id_pc;
    if_id_instr_next = if_id_instr;
    if_id_valid_next = if_id_valid;
    fetch_count_next = fetch_count;

    unique case (action)
      ACT_RESET: begin
        pc_next          = RESET_PC;
        if_id_pc_next    = 32'h0000_0000;
        if_id_instr_next = NOP_INSTR;
        if_id_valid_next = 1'b0;
        fetch_count_next = 32'h0000_0000;
      end

      ACT_REDIRECT: begin
        // Target is forced word-aligned. The instruction currently in IF/ID
        // (stalled or not) is on the wrong path, so it becomes a bubble.
        pc_next          = redirect_pc & ~32'h0000_0003;
        if_id_pc_next    = 32'h0000_0000;
        if_id_instr_next = NOP_INSTR;
        if_id_valid_next = 1'b0;
      end

      ACT_STALL: begin
        // Everything holds, including a bubble already sitting in IF/ID.
      end

      ACT_ADVANCE: begin
        // The increments wrap modulo 2^32 by construction of the width.
        pc_next          = pc + 32'd4;
        if_id_pc_next    = pc;
        if_id_instr_next = imem_data;
        if_id_valid_next = 1'b1;
        fetch_count_next = fetch_count + 32'd1;
      end

      default: begin
        // Unreachable; hold defaults above apply.
      end
    endcase
  end

  // State registers. Reset is synchronous: it is already folded into the
  // next-state logic as the highest-priority action.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    pc          <= pc_next;
    if_id_pc    <= if_id_pc_next;
    if_id_instr <= if_id_instr_next;
    if_id_valid <= if_id_valid_next;
    fetch_count <= fetch_count_next;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the asynchronous instruction ROM.
- Owns the program counter and drives the ROM's word-index address. Captures the combinational instruction word returned by the ROM into the IF/ID pipeline register.
- Handles decode-stage stall and execute-stage redirect (branch/jump), including the bubble insertion each one needs.

Parameters:
- RESET_PC, 32'h00000000, byte address loaded into the PC on reset.
- IMEM_AW, 10, word-address width of the instruction ROM (1024 words).
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents (load-use hazard from decode).
- redirect  in  1  branch taken / jump: load PC from redirect_pc and squash IF/ID.
- redirect_pc  in  32  byte-address redirect target.
- imem_addr  out  32  word index to the ROM: {(32-IMEM_AW)'b0, pc[IMEM_AW+1:2]}, combinational from pc.
- imem_data  in  32  instruction word returned combinationally by the ROM.
- pc  out  32  current fetch PC (byte address, registered).
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset values (rst high at a rising edge):
  - pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, fetch_count=0.
  - rst overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr is purely combinational from pc. Latency is 0 from pc to imem_addr and 1 cycle from pc to IF/ID.
- Priority at each rising edge is rst > redirect > stall > advance.
- Redirect:
  - pc <= {redirect_pc[31:2],2'b00}; redirect_pc[1:0] are ignored.
  - IF/ID is loaded with a bubble: valid=0, instr=NOP_INSTR, if_id_pc=0.
  - fetch_count is unchanged.
  - Redirect wins over a simultaneous stall; the stalled IF/ID content is discarded.
- Stall (no redirect): pc, if_id_pc, if_id_instr, if_id_valid and fetch_count all hold.
- Advance (neither redirect nor stall):
  - if_id_instr <= imem_data, if_id_pc <= pc, if_id_valid <= 1.
  - pc <= pc + 32'd4.
  - fetch_count <= fetch_count + 1.
- Arithmetic and width rules:
  - The PC increment is modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
  - fetch_count wraps modulo 2^32.
  - imem_addr uses only pc[IMEM_AW+1:2], so it wraps every 4*2^IMEM_AW bytes. This keeps the ROM index always in range and never produces an X read.
- First fetch after reset: the cycle after rst deasserts, IF/ID holds mem[RESET_PC>>2] with valid=1.
- Back-to-back redirects: each one reloads the PC; only the last target is fetched. IF/ID stays invalid throughout.
- A stall asserted while IF/ID is invalid holds the bubble.
- No combinational path from stall or redirect to imem_addr; only registered pc drives it.

Test Plan:
- Reset then free-run, ROM loaded with mem[i]=32'h1000_0000+i:
  - After 3 advance edges: pc=12, if_id_pc=8, if_id_instr=32'h10000002, valid=1, fetch_count=3.
  - imem_addr sequence is 0,1,2,3.
- Stall for 2 cycles starting when pc=8:
  - pc stays 8, if_id_instr stays 32'h10000001, fetch_count stays 2.
  - On release, the next edge gives if_id_pc=8, pc=12.
- Redirect with redirect_pc=32'h40 asserted together with stall, when pc=16:
  - Next edge: pc=32'h40, valid=0, if_id_instr=32'h00000013, fetch_count unchanged.
  - Following edge: if_id_instr=32'h10000010.
- Misaligned redirect_pc=32'h23 -> pc=32'h20, imem_addr=8.
- Wrap-around:
  - Redirect to 32'hFFFFFFFC, then advance -> if_id_pc=32'hFFFFFFFC, pc=0.
  - imem_addr shows 1023, then 0.
- rst asserted mid-stall with pc=32'h40 and valid=1:
  - Next edge: pc=RESET_PC, valid=0, fetch_count=0, regardless of stall/redirect.
